// File: rtl/float_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : float_multiplier / float_multiplier_arbiter
// Purpose  : Round-robin arbiter plus two-stage pipeline that shares one
//            combinational IEEE-754 single-precision multiplier between
//            NUM_REQ requesters. Results come back on one shared channel,
//            tagged with the index of the requester that issued them.
// Ports    : clk, rst (async, active high)
//            in_valid/in_ready [NUM_REQ]  per-requester handshake
//            in_a/in_b [NUM_REQ*32]       operands, requester i at [32i+:32]
//            out_valid/out_ready          shared result handshake
//            out_data, out_id             product and requester tag
//            out_exception/overflow/underflow  multiplier flags
//            busy                         either pipeline stage occupied
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Combinational single-precision multiplier.
//   - any operand with exponent 0xFF      -> exception, result 0
//   - any operand with exponent 0x00      -> signed zero, no flags
//   - biased result exponent >= 255       -> overflow, {sign, 0xFF, 0}
//   - biased result exponent <= 0         -> underflow, {sign, 0}
//   - otherwise round-to-nearest-even of the exact 48-bit significand product
// ----------------------------------------------------------------------------
module float_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);

  logic        w_sign;
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic        w_exc;
  logic        w_zero;
  logic [47:0] w_prod;
  logic        w_norm;
  logic [22:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_mant_r;
  logic [9:0]  w_exp;

  always_comb begin
    w_sign   = a[31] ^ b[31];
    w_ea     = a[30:23];
    w_eb     = b[30:23];
    w_exc    = (&w_ea) | (&w_eb);
    w_zero   = (w_ea == 8'd0) | (w_eb == 8'd0);
    w_prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    // Product of two [1,2) significands lies in [1,4); bit 47 says which half.
    w_norm   = w_prod[47];
    if (w_norm) begin
      w_mant   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
    end else begin
      w_mant   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {23'd0, w_round_up};
    // Rounding carry out of the mantissa bumps the exponent; the mantissa
    // field is then all zeros, which w_mant_r[22:0] already holds.
    // Signed 10-bit range (-125..385) covers every reachable value.
    w_exp = {2'b00, w_ea} + {2'b00, w_eb} + {9'd0, w_norm}
          + {9'd0, w_mant_r[23]} - 10'd127;

    result    = 32'd0;
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (w_exc) begin
      exception = 1'b1;
    end else if (w_zero) begin
      result = {w_sign, 31'd0};
    end else if ($signed(w_exp) >= 10'sd255) begin
      overflow = 1'b1;
      result   = {w_sign, 8'hFF, 23'd0};
    end else if ($signed(w_exp) <= 10'sd0) begin
      underflow = 1'b1;
      result    = {w_sign, 31'd0};
    end else begin
      result = {w_sign, w_exp[7:0], w_mant_r[22:0]};
    end
  end

endmodule

// ----------------------------------------------------------------------------
// Arbiter and pipeline wrapper.
// ----------------------------------------------------------------------------
module float_multiplier_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    in_valid,
  output logic [NUM_REQ-1:0]    in_ready,
  input  logic [NUM_REQ*32-1:0] in_a,
  input  logic [NUM_REQ*32-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_exception,
  output logic                  out_overflow,
  output logic                  out_underflow,
  output logic                  busy
);

  localparam logic [ID_W:0]   c_NUM_EXT = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

  // Operand stage
  logic            r_s1_valid;
  logic [31:0]     r_s1_a;
  logic [31:0]     r_s1_b;
  logic [ID_W-1:0] r_s1_id;
  // Result stage
  logic            r_s2_valid;
  logic [31:0]     r_s2_data;
  logic            r_s2_exc;
  logic            r_s2_ovf;
  logic            r_s2_unf;
  logic [ID_W-1:0] r_s2_id;
  // Round-robin pointer: the index searched first
  logic [ID_W-1:0] r_ptr;

  logic            w_s2_adv;
  logic            w_s1_can_load;
  logic            w_found;
  logic [ID_W-1:0] w_winner;
  logic [ID_W:0]   w_idx;
  logic            w_xfer;
  logic [ID_W-1:0] w_ptr_next;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;
  logic [31:0]     w_mul_res;
  logic            w_mul_exc;
  logic            w_mul_ovf;
  logic            w_mul_unf;

  assign w_s2_adv      = r_s1_valid & (~r_s2_valid | out_ready);
  assign w_s1_can_load = ~r_s1_valid | w_s2_adv;

  // Search ptr, ptr+1, ... wrapping modulo NUM_REQ; first valid wins.
  // The wrap is a single subtract because ptr and the offset are both
  // below NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + k[ID_W:0];
      if (w_idx >= c_NUM_EXT) begin
        w_idx = w_idx - c_NUM_EXT;
      end
      if (!w_found && in_valid[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_xfer     = w_found & w_s1_can_load;
  assign w_ptr_next = (w_winner == c_LAST_ID) ? '0 : w_winner + 1'b1;
  assign w_sel_a    = in_a[{w_winner, 5'd0} +: 32];
  assign w_sel_b    = in_b[{w_winner, 5'd0} +: 32];

  // Gated by rst so that no requester sees an accept while reset is held.
  always_comb begin
    in_ready = '0;
    if (w_xfer && !rst) begin
      in_ready[w_winner] = 1'b1;
    end
  end

  float_multiplier u_fmul (
    .a         (r_s1_a),
    .b         (r_s1_b),
    .result    (w_mul_res),
    .exception (w_mul_exc),
    .overflow  (w_mul_ovf),
    .underflow (w_mul_unf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= 32'd0;
      r_s2_exc   <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_unf   <= 1'b0;
      r_s2_id    <= '0;
      r_ptr      <= '0;
    end else begin
      if (w_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= w_sel_a;
        r_s1_b     <= w_sel_b;
        r_s1_id    <= w_winner;
        r_ptr      <= w_ptr_next;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_mul_res;
        r_s2_exc   <= w_mul_exc;
        r_s2_ovf   <= w_mul_ovf;
        r_s2_unf   <= w_mul_unf;
        r_s2_id    <= r_s1_id;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_s2_valid;
  assign out_data      = r_s2_data;
  assign out_id        = r_s2_id;
  assign out_exception = r_s2_exc;
  assign out_overflow  = r_s2_ovf;
  assign out_underflow = r_s2_unf;
  assign busy          = r_s1_valid | r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_float_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_multiplier_arbiter
// Purpose  : Self-checking bench for float_multiplier_arbiter (NUM_REQ=4).
//            Directed vectors plus a random soak against a scoreboard whose
//            reference product is computed through double-precision reals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_multiplier_arbiter;

  localparam int NUM_REQ = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic         out_exception;
  logic         out_overflow;
  logic         out_underflow;
  logic         busy;

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [3:0]   last_acc;

  // Scoreboard state: {exception, overflow, underflow, data}
  logic [34:0]  exp_q [NUM_REQ][$];
  int           wait_cnt [NUM_REQ];
  logic [3:0]   prev_pending;
  logic [3:0]   m_fire;
  logic [34:0]  m_exp;

  float_multiplier_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_id        (out_id),
    .out_exception (out_exception),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference multiply: product of two singles is exact in double, then
  // rounded to nearest-even single by hand.
  function automatic logic [34:0] ref_fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] da_bits;
    logic [63:0] db_bits;
    logic [63:0] p_bits;
    real         p;
    int          e;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, 32'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {3'b000, s, 31'd0};
    da_bits = {1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
    db_bits = {1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
    p       = $bitstoreal(da_bits) * $bitstoreal(db_bits);
    p_bits  = $realtobits(p);
    e       = int'(p_bits[62:52]) - 1023 + 127;
    m       = p_bits[51:29];
    if (p_bits[28] && ((|p_bits[27:0]) || m[0])) begin
      if (m == 23'h7FFFFF) begin
        m = 23'd0;
        e = e + 1;
      end else begin
        m = m + 23'd1;
      end
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b001, s, 31'd0};
    return {3'b000, s, e[7:0], m};
  endfunction

  // Monitor at the falling edge: what is seen here is what the next rising
  // edge will act on.
  initial begin
    prev_pending = '0;
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          exp_q[i].delete();
          wait_cnt[i] = 0;
        end
        prev_pending = '0;
      end else begin
        check_eq("hold_valid", 64'(prev_pending & ~in_valid), 64'd0);
        check_eq("ready_onehot0", 64'($onehot0(in_ready)), 64'd1);
        check_eq("ready_needs_valid", 64'(in_ready & ~in_valid), 64'd0);
        m_fire = in_valid & in_ready;
        if (m_fire != 4'd0) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (m_fire[i]) begin
              check_eq("fair_wait", 64'(wait_cnt[i] <= NUM_REQ - 1), 64'd1);
              wait_cnt[i] = 0;
              exp_q[i].push_back(ref_fmul(in_a[32*i +: 32], in_b[32*i +: 32]));
            end else if (in_valid[i]) begin
              wait_cnt[i]++;
            end
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q[out_id].size() == 0) begin
            check_eq("sb_unexpected", 64'd1, 64'd0);
          end else begin
            m_exp = exp_q[out_id].pop_front();
            check_eq("sb_result",
                     64'({out_exception, out_overflow, out_underflow, out_data}),
                     64'(m_exp));
          end
        end
        prev_pending = in_valid & ~in_ready;
      end
    end
  end

  // One clock: note who is accepted, advance, retire accepted requests.
  task automatic cycle();
    #1;
    last_acc = in_ready & in_valid;
    @(posedge clk);
    #1;
    in_valid = in_valid & ~last_acc;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Operand k for requester i: (1 + k/16) * 2.0, so the product is
  // 0x40000000 | (k << 19).
  task automatic load_op(input int i, input int k);
    in_a[32*i +: 32] = 32'h3F800000 | (32'(k & 15) << 19);
    in_b[32*i +: 32] = 32'h40000000;
  endtask

  task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b);
    in_a[32*id +: 32] = a;
    in_b[32*id +: 32] = b;
    in_valid = 4'b0001 << id;
    #1;
    check_eq("issue_ready", 64'(in_ready), 64'(4'b0001 << id));
    cycle();
    check_eq("lat_not_yet", 64'(out_valid), 64'd0);
    cycle();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    logic [7:0]  e;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'hFF;
    else if (sel == 2) e = 8'($urandom_range(200, 254));
    else if (sel == 3) e = 8'($urandom_range(1, 40));
    else               e = 8'($urandom_range(100, 154));
    return {r[31], e, r[22:0]};
  endfunction

  int  k;
  int  cnt;
  int  tot;
  logic [1:0] seq3 [3];

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    last_acc  = '0;
    seq3[0] = 2'd0; seq3[1] = 2'd1; seq3[2] = 2'd3;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data",  64'(out_data), 64'd0);
    check_eq("rst_out_id",    64'(out_id), 64'd0);
    check_eq("rst_flags",     64'({out_exception, out_overflow, out_underflow}), 64'd0);
    check_eq("rst_busy",      64'(busy), 64'd0);
    check_eq("rst_in_ready",  64'(in_ready), 64'd0);
    in_valid = 4'h0;
    rst      = 1'b0;

    // Single op: 1.5 * 2.0 from requester 1
    out_ready = 1'b1;
    issue_one(1, 32'h3FC00000, 32'h40000000);
    check_eq("single_valid", 64'(out_valid), 64'd1);
    check_eq("single_data",  64'(out_data), 64'h40400000);
    check_eq("single_id",    64'(out_id), 64'd1);
    check_eq("single_flags", 64'({out_exception, out_overflow, out_underflow}), 64'd0);

    // Special cases
    issue_one(0, 32'h7F000000, 32'h7F000000);
    check_eq("ovf_data", 64'(out_data), 64'h7F800000);
    check_eq("ovf_flags", 64'({out_exception, out_overflow, out_underflow}), 64'b010);
    issue_one(0, 32'h7F800000, 32'h3F800000);
    check_eq("exc_data", 64'(out_data), 64'h00000000);
    check_eq("exc_flags", 64'({out_exception, out_overflow, out_underflow}), 64'b100);
    issue_one(0, 32'h80000000, 32'h40000000);
    check_eq("negzero_data", 64'(out_data), 64'h80000000);
    check_eq("negzero_flags", 64'({out_exception, out_overflow, out_underflow}), 64'b000);

    // Round-robin with all requesters active
    reset_dut();
    out_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) load_op(i, i);
    k = NUM_REQ;
    in_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check_eq("rr_grant", 64'(last_acc), 64'(4'b0001 << (c % 4)));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_acc[i]) begin
          load_op(i, k);
          k++;
          in_valid[i] = 1'b1;
        end
      end
      if (c == 0) begin
        check_eq("rr_latency", 64'(out_valid), 64'd0);
      end else begin
        check_eq("rr_valid", 64'(out_valid), 64'd1);
        check_eq("rr_id", 64'(out_id), 64'((c - 1) % 4));
        if (c <= 4) check_eq("rr_data", 64'(out_data), 64'(32'h40000000 | (32'(c - 1) << 19)));
      end
    end

    // Round-robin with requester 2 idle
    in_valid = 4'h0;
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) load_op(i, i);
    in_valid = 4'b1011;
    for (int c = 0; c < 9; c++) begin
      cycle();
      check_eq("rr3_grant", 64'(last_acc), 64'(4'b0001 << seq3[c % 3]));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_acc[i]) in_valid[i] = 1'b1;
      end
      if (c >= 1) check_eq("rr3_id", 64'(out_id), 64'(seq3[(c - 1) % 3]));
    end

    // Backpressure: requester 0 streaming, consumer stalled
    in_valid = 4'h0;
    reset_dut();
    out_ready = 1'b0;
    k   = 0;
    cnt = 0;
    load_op(0, k);
    in_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (last_acc[0]) begin
        cnt++;
        k++;
        load_op(0, k);
        in_valid[0] = 1'b1;
      end
      if (c >= 1) begin
        check_eq("bp_valid", 64'(out_valid), 64'd1);
        check_eq("bp_data",  64'(out_data), 64'h40000000);
        check_eq("bp_id",    64'(out_id), 64'd0);
      end
    end
    check_eq("bp_accepts", 64'(cnt), 64'd2);
    check_eq("bp_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    check_eq("bp_drain_acc", 64'(last_acc), 64'b0001);
    check_eq("bp_drain1", 64'(out_data), 64'h40080000);
    cycle();
    check_eq("bp_drain2_valid", 64'(out_valid), 64'd1);
    check_eq("bp_drain2", 64'(out_data), 64'h40100000);
    cycle();
    check_eq("bp_empty", 64'(out_valid), 64'd0);

    // Reset with both stages full
    reset_dut();
    out_ready = 1'b0;
    load_op(1, 3);
    load_op(2, 5);
    in_valid = 4'b0110;
    cycle();
    cycle();
    check_eq("mf_full_busy", 64'(busy), 64'd1);
    check_eq("mf_full_valid", 64'(out_valid), 64'd1);
    load_op(2, 6);
    load_op(3, 7);
    in_valid = 4'b1100;
    rst = 1'b1;
    #1;
    check_eq("mf_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mf_rst_busy", 64'(busy), 64'd0);
    check_eq("mf_rst_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("mf_first_grant", 64'(in_ready), 64'b0100);
    cycle();
    check_eq("mf_no_stale", 64'(out_valid), 64'd0);
    cycle();
    check_eq("mf_out1_valid", 64'(out_valid), 64'd1);
    check_eq("mf_out1_id", 64'(out_id), 64'd2);
    check_eq("mf_out1_data", 64'(out_data), 64'h40300000);
    cycle();
    check_eq("mf_out2_id", 64'(out_id), 64'd3);
    cycle();
    check_eq("mf_idle", 64'(out_valid), 64'd0);

    // Random soak
    reset_dut();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!in_valid[i] && ($urandom_range(0, 1) == 1)) begin
          in_a[32*i +: 32] = rand_operand();
          in_b[32*i +: 32] = rand_operand();
          in_valid[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (in_valid == 4'h0 && !busy) break;
      cycle();
    end
    check_eq("drain_busy", 64'(busy), 64'd0);
    check_eq("drain_pending", 64'(in_valid), 64'd0);
    @(negedge clk);
    tot = 0;
    for (int i = 0; i < NUM_REQ; i++) tot += exp_q[i].size();
    check_eq("drain_sb_empty", 64'(tot), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_multiplier_arbiter.md
# float_multiplier_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one combinational `float_multiplier` datapath (IEEE-754 single, flags Exception/Overflow/Underflow) among `NUM_REQ` requesters. Each requester presents an operand pair on a valid/ready handshake. The block issues at most one pair per cycle into a registered operand stage, then into a registered result stage. Results return on a single shared output channel tagged with the requester index. It sits between the scalar compute units of a layer and the shared float multiplier instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester tag. Derived; not overridden.
- `clk` input, 1 bit: clock; all state on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, `NUM_REQ` bits: request valid, one bit per requester.
- `in_ready` output, `NUM_REQ` bits: one-hot grant/accept, or all zero.
- `in_a` input, `NUM_REQ*32` bits: operand A of requester i at bits [32i+31:32i].
- `in_b` input, `NUM_REQ*32` bits: operand B, same packing as `in_a`.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, 32 bits: product.
- `out_id` output, `ID_W` bits: index of the requester that issued the operation.
- `out_exception`, `out_overflow`, `out_underflow` output, 1 bit each: multiplier flags for this result.
- `busy` output, 1 bit: S1 valid OR S2 valid.

## Operation
- **Pipeline stage S1 (operand stage):** `s1_valid`, `s1_a`, `s1_b`, `s1_id`. The multiplier is fed combinationally from S1.
- **Pipeline stage S2 (result stage):** `s2_valid`, result, flags, id. Drives the `out_*` ports directly.
- **Advance conditions:**
  - `s2_adv = s1_valid & (~s2_valid | out_ready)`
  - `s1_can_load = ~s1_valid | s2_adv`
- **Arbitration:**
  - Round-robin pointer `ptr` (`ID_W` bits).
  - Winner = first i with `in_valid[i]=1`, searching ptr, ptr+1, …, wrapping modulo `NUM_REQ`.
  - `in_ready[winner]=1` only when `s1_can_load=1`. All other `in_ready` bits are 0.
  - `in_ready` is combinational from `in_valid`, `ptr` and stall state; no combinational path from `out_ready` except through `s2_adv`.
- **Handshake:**
  - A transfer occurs when `in_valid[i] & in_ready[i]`.
  - On a transfer, S1 loads that requester's operands and id, and `ptr <= (winner+1) mod NUM_REQ`.
  - With no transfer, `ptr` holds.
  - Requesters hold valid and data stable until accepted. A requester may not drop `in_valid` before acceptance (protocol violation; bench asserts).
- **S1 update:**
  - When `s2_adv` fires and nothing loads S1, `s1_valid <= 0`.
  - Simultaneous S2 drain and S1 load in one cycle is allowed; full throughput is 1 op/cycle.
- **S2 update:**
  - On `s2_adv`, S2 captures the multiplier result, the three flags and `s1_id`, and sets `s2_valid <= 1`.
  - Else, if `out_ready`, `s2_valid <= 0`.
  - Else S2 holds all fields stable.
- **No arithmetic in this block:** results and flags are exactly the multiplier's outputs, including its special-case behaviour:
  - Exception forces result 0.
  - Overflow gives {sign, 0xFF, 0}.
  - Underflow or zero gives {sign, 0}.

## Timing
- **Reset (async assert, sync release):** `s1_valid=0`, `s2_valid=0`, `ptr=0`. Therefore `out_valid=0`, `out_data=0`, `out_id=0`, all flags 0, `busy=0`, `in_ready` all 0 during reset.
- **Latency:** input accepted at edge N gives `out_valid=1` after edge N+1, i.e. 2 cycles to output.
- **Backpressure:**
  - With `out_ready=0`, at most 2 ops are held.
  - `in_ready` stays all 0 once S1 and S2 are both full.
  - The held output is stable every cycle.
- **Reset mid-operation:** in-flight ops are discarded without output; no partial result appears after release.
- **Single requester with `in_valid` continuously high:** granted every cycle that `s1_can_load=1`.
- **Fairness:** a requester waits at most `NUM_REQ-1` grants to others.

## Test plan
- **Single op:** req 1 sends `a=0x3FC00000` (1.5), `b=0x40000000` (2.0), `out_ready=1` → after 2 cycles `out_data=0x40400000`, `out_id=1`, flags 0.
- **Round-robin:** all 4 `in_valid` held high with fresh data each accept, `out_ready=1` → `out_id` sequence 0,1,2,3,0,1… with `out_valid` high every cycle from cycle 2. Then drop req 2 only → sequence 0,1,3,0,1,3.
- **Special cases:**
  - `0x7F000000*0x7F000000` → `0x7F800000`, `out_overflow=1`.
  - `0x7F800000*0x3F800000` → `0x00000000`, `out_exception=1`.
  - `0x80000000*0x40000000` → `0x80000000`, no flags.
- **Backpressure:** stream from req 0 with `out_ready=0` for 5 cycles → exactly 2 accepts, then `in_ready=0`. `out_data`/`out_id` stable throughout. Restoring `out_ready` drains in order with no loss or duplication.
- **Reset mid-flight:** both stages full, `rst` pulsed for 1 cycle → `out_valid=0` and `busy=0` immediately. After release, the first grant goes to the lowest valid index (`ptr=0`).
- **Random soak:** random `in_valid`/`out_ready` over 10k cycles → scoreboard matches a reference float model per id. Per-requester order is preserved, and no requester waits more than `NUM_REQ-1` foreign grants.
